// File: rtl/le_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : le_cfg_pkg
// Description : Shared constants, function opcodes, FSM state encoding and
//               helpers for the logic-element configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package le_cfg_pkg;

    // Field widths of one logic-element configuration record
    localparam int FUNC_W   = 3;
    localparam int IDX_W    = 6;
    localparam int LE_CFG_W = FUNC_W + 2 * IDX_W;

    // Function opcodes carried in the func field (all eight are legal)
    localparam logic [FUNC_W-1:0] FUNC_AND  = 3'd0;
    localparam logic [FUNC_W-1:0] FUNC_OR   = 3'd1;
    localparam logic [FUNC_W-1:0] FUNC_NOT  = 3'd2;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 3'd3;
    localparam logic [FUNC_W-1:0] FUNC_XNOR = 3'd4;
    localparam logic [FUNC_W-1:0] FUNC_NAND = 3'd5;
    localparam logic [FUNC_W-1:0] FUNC_NOR  = 3'd6;
    localparam logic [FUNC_W-1:0] FUNC_BUF  = 3'd7;

    // Frame start pattern
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Loader FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_HUNT   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_CHECK  = 3'd2;
    localparam state_t ST_COMMIT = 3'd3;
    localparam state_t ST_REJECT = 3'd4;

    // True when an input index addresses past the end of the input vector
    function automatic logic idx_out_of_range(input logic [IDX_W-1:0] idx,
                                              input int               num_inputs);
        return (int'(idx) >= num_inputs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/le_cfg_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : le_cfg_sync_detect
// Description : 8-bit LSB-first serial window that flags the sync word. The
//               match output looks at the window including the bit being
//               shifted in, so the frame can start on the very next bit.
// Revision    : 1.0 - initial release
// ============================================================================
module le_cfg_sync_detect
    import le_cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_shift_en,
    input  logic i_bit,
    output logic o_match
);

    logic [7:0] r_window;
    logic [7:0] w_window_next;

    // Newest bit enters at the MSB
    assign w_window_next = {i_bit, r_window[7:1]};
    assign o_match       = i_shift_en && (w_window_next == SYNC_WORD);

    // Window shift register; clear wins over shift so stale bits never match
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_window <= '0;
        end else if (i_shift_en) begin
            r_window <= w_window_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/le_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : le_config_loader
// Description : Serial configuration loader for the virtual-FPGA logic
//               elements. Hunts for the sync word, shifts per-element
//               func/A/B fields into a shadow register, range-checks the
//               indices and commits the whole set atomically to the active
//               buses. Optional macro LE_CFG_PARITY_EN adds an even-parity
//               bit after the payload, checked in the CHECK state.
// Revision    : 1.0 - initial release
// ============================================================================
module le_config_loader
    import le_cfg_pkg::*;
#(
    parameter int         NUM_LE     = 4,
    parameter int         NUM_INPUTS = 33,
    parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    input  logic                       cfg_data,
    output logic                       cfg_ready,
    output logic [FUNC_W*NUM_LE-1:0]   conf_func_bus,
    output logic [2*IDX_W*NUM_LE-1:0]  conf_ins_bus,
    output logic                       cfg_loaded,
    output logic                       cfg_done,
    output logic                       cfg_error,
    output logic                       busy
);

    localparam int                 c_payload_w = LE_CFG_W * NUM_LE;
    localparam int                 c_cnt_w     = $clog2(c_payload_w);
    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(c_payload_w - 1);
    localparam logic [3:0]         c_a_end     = 4'(FUNC_W + IDX_W - 1);
    localparam logic [3:0]         c_b_end     = 4'(LE_CFG_W - 1);

    state_t                      r_state;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [3:0]                  r_off;
    logic [IDX_W-2:0]            r_field;
    logic                        r_range;
    logic [c_payload_w-1:0]      r_shadow;
    logic [FUNC_W*NUM_LE-1:0]    r_func;
    logic [2*IDX_W*NUM_LE-1:0]   r_ins;
    logic                        r_loaded;
    logic                        r_done;
    logic                        r_error;
`ifdef LE_CFG_PARITY_EN
    logic                        r_par;
`endif

    logic                        w_xfer;
    logic                        w_match;
    logic                        w_field_end;
    logic [IDX_W-1:0]            w_field_next;
    logic [FUNC_W*NUM_LE-1:0]    w_shadow_func;
    logic [2*IDX_W*NUM_LE-1:0]   w_shadow_ins;

    assign cfg_ready     = (r_state == ST_HUNT) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign busy          = (r_state == ST_LOAD) || (r_state == ST_CHECK) || (r_state == ST_COMMIT);
    assign w_xfer        = cfg_valid && cfg_ready;
    assign conf_func_bus = r_func;
    assign conf_ins_bus  = r_ins;
    assign cfg_loaded    = r_loaded;
    assign cfg_done      = r_done;
    assign cfg_error     = r_error;

    // Index field completes on its sixth bit; include the incoming bit
    assign w_field_next = {cfg_data, r_field};
    assign w_field_end  = (r_off == c_a_end) || (r_off == c_b_end);

    // Shadow record layout per element is {B, A, func}, matching bit order
    for (genvar i = 0; i < NUM_LE; i++) begin : g_le_map
        assign w_shadow_func[FUNC_W*i +: FUNC_W] = r_shadow[LE_CFG_W*i +: FUNC_W];
        assign w_shadow_ins[2*IDX_W*i +: 2*IDX_W] = r_shadow[LE_CFG_W*i + FUNC_W +: 2*IDX_W];
    end

    // Sync window only sees bits accepted while hunting; cleared on return to HUNT
    le_cfg_sync_detect #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_clr      ((r_state == ST_COMMIT) || (r_state == ST_REJECT)),
        .i_shift_en (w_xfer && (r_state == ST_HUNT)),
        .i_bit      (cfg_data),
        .o_match    (w_match)
    );

    // Loader FSM with registered shadow/active state and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_HUNT;
            r_cnt    <= '0;
            r_off    <= '0;
            r_field  <= '0;
            r_range  <= 1'b0;
            r_shadow <= '0;
            r_func   <= '0;
            r_ins    <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
`ifdef LE_CFG_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                        r_off   <= '0;
                        r_range <= 1'b0;
                        r_error <= 1'b0;
`ifdef LE_CFG_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_shadow[r_cnt] <= cfg_data;
                        r_field         <= w_field_next[IDX_W-1:1];
`ifdef LE_CFG_PARITY_EN
                        r_par           <= r_par ^ cfg_data;
`endif
                        // Flag bad indices but keep consuming to preserve framing
                        if (w_field_end && idx_out_of_range(w_field_next, NUM_INPUTS)) begin
                            r_range <= 1'b1;
                        end
                        r_off <= (r_off == c_b_end) ? 4'd0 : r_off + 4'd1;
                        if (r_cnt == c_last_bit) begin
`ifdef LE_CFG_PARITY_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_COMMIT;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
`ifdef LE_CFG_PARITY_EN
                ST_CHECK: begin
                    if (w_xfer) begin
                        r_state <= ((r_par ^ cfg_data) || r_range) ? ST_REJECT : ST_COMMIT;
                    end
                end
`endif
                ST_COMMIT: begin
                    if (r_range) begin
                        r_state <= ST_REJECT;
                    end else begin
                        r_func   <= w_shadow_func;
                        r_ins    <= w_shadow_ins;
                        r_done   <= 1'b1;
                        r_loaded <= 1'b1;
                        r_state  <= ST_HUNT;
                    end
                end
                ST_REJECT: begin
                    r_error <= 1'b1;
                    r_state <= ST_HUNT;
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_le_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_le_config_loader
// Description : Self-checking bench for le_config_loader (NUM_LE=2). Stimulus
//               pushes expected commit/reject events into a queue; a monitor
//               pops and compares whenever the DUT pulses cfg_done or raises
//               cfg_error. Honours LE_CFG_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_le_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_data;
    logic        cfg_ready;
    logic [5:0]  conf_func_bus;
    logic [23:0] conf_ins_bus;
    logic        cfg_loaded;
    logic        cfg_done;
    logic        cfg_error;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        is_err;
        logic        loaded;
        logic [5:0]  func;
        logic [23:0] ins;
    } exp_t;

    exp_t exp_q[$];

    le_config_loader #(
        .NUM_LE     (2),
        .NUM_INPUTS (33),
        .SYNC_WORD  (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .conf_func_bus (conf_func_bus),
        .conf_ins_bus  (conf_ins_bus),
        .cfg_loaded    (cfg_loaded),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Payload layout: element 0 first, each {B, A, func}
    function automatic logic [29:0] mk(input int f0, input int a0, input int b0,
                                       input int f1, input int a1, input int b1);
        logic [29:0] p;
        p[2:0]   = 3'(f0);
        p[8:3]   = 6'(a0);
        p[14:9]  = 6'(b0);
        p[17:15] = 3'(f1);
        p[23:18] = 6'(a1);
        p[29:24] = 6'(b1);
        return p;
    endfunction

    function automatic exp_t ev(input logic is_err, input logic [5:0] f, input logic [23:0] ins);
        exp_t e;
        e.is_err = is_err;
        e.loaded = 1'b1;
        e.func   = f;
        e.ins    = ins;
        return e;
    endfunction

    // Offer one bit and hold it until the DUT accepts it (bounded wait)
    task automatic send_bit(input logic b);
        bit taken = 0;
        cfg_valid = 1'b1;
        cfg_data  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                @(posedge clk);
                #1;
                taken = 1;
            end
        end
        if (!taken) begin
            n_total++;
            $display("FAIL send_timeout: got ready=0 for 50 cycles required ready=1");
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_payload(input logic [29:0] p, input bit bad_par, input bit gap);
        for (int i = 0; i < 30; i++) begin
            send_bit(p[i]);
            if (gap && i != 29) idle(1);
        end
`ifdef LE_CFG_PARITY_EN
        send_bit((^p) ^ bad_par);
`else
        if (bad_par) $display("note: parity disabled in this build");
`endif
    endtask

    task automatic send_frame(input logic [29:0] p, input bit bad_par, input bit gap);
        send_byte(8'hA5);
        send_payload(p, bad_par, gap);
    endtask

    // Monitor: compare each DUT event against the head of the scoreboard
    initial begin
        logic prev_err = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_err = 1'b0;
            end else begin
                if (cfg_done || (cfg_error && !prev_err)) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_event: got done=%0b error=%0b required no event",
                                 cfg_done, cfg_error);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_is_err", {31'd0, !cfg_done}, {31'd0, e.is_err});
                        check("ev_func",   {26'd0, conf_func_bus}, {26'd0, e.func});
                        check("ev_ins",    {8'd0, conf_ins_bus}, {8'd0, e.ins});
                        check("ev_loaded", {31'd0, cfg_loaded}, {31'd0, e.loaded});
                    end
                end
                prev_err = cfg_error;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [29:0] p_a, p_bad, p_g, p_n, p_e;
        p_a   = mk(3, 5, 32, 7, 0, 1);
        p_bad = mk(3, 5, 32, 7, 0, 33);
        p_g   = mk(1, 2, 3, 4, 31, 30);
        p_n   = mk(0, 32, 0, 5, 17, 9);
        p_e   = mk(5, 20, 31, 2, 32, 7);   // first 8 payload bits are 1,0,1,0,0,1,0,1

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_func",   {26'd0, conf_func_bus}, 32'd0);
        check("rst_ins",    {8'd0, conf_ins_bus}, 32'd0);
        check("rst_loaded", {31'd0, cfg_loaded}, 32'd0);
        check("rst_done",   {31'd0, cfg_done}, 32'd0);
        check("rst_error",  {31'd0, cfg_error}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_ready",  {31'd0, cfg_ready}, 32'd1);

        // Good frame with latency checks around the commit
        exp_q.push_back(ev(1'b0, 6'b111_011, {12'h040, 12'h805}));
        send_frame(p_a, 1'b0, 1'b0);
        @(negedge clk);
        check("commit_done_early", {31'd0, cfg_done}, 32'd0);
        check("commit_ready",      {31'd0, cfg_ready}, 32'd0);
        check("commit_busy",       {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("commit_done_pulse", {31'd0, cfg_done}, 32'd1);
        idle(4);
        check("a_loaded", {31'd0, cfg_loaded}, 32'd1);
        check("a_idle_busy", {31'd0, busy}, 32'd0);

        // Out-of-range index B=33: reject, buses unchanged
        exp_q.push_back(ev(1'b1, 6'b111_011, {12'h040, 12'h805}));
        send_frame(p_bad, 1'b0, 1'b0);
        idle(6);
        check("range_error", {31'd0, cfg_error}, 32'd1);

`ifdef LE_CFG_PARITY_EN
        // Flipped parity rejects; next good frame clears the error and commits
        exp_q.push_back(ev(1'b1, 6'b111_011, {12'h040, 12'h805}));
        send_frame(p_g, 1'b1, 1'b0);
        idle(6);
        check("parity_error", {31'd0, cfg_error}, 32'd1);
        exp_q.push_back(ev(1'b0, 6'b100_001, {12'h79F, 12'h0C2}));
        send_frame(p_g, 1'b0, 1'b0);
        idle(6);
        check("parity_recover_error", {31'd0, cfg_error}, 32'd0);
`endif

        // Noise before sync, payload with idle cycles between bits
        exp_q.push_back(ev(1'b0, 6'b101_000, {12'h251, 12'h020}));
        send_byte(8'h5A);
        send_byte(8'hFF);
        send_frame(p_n, 1'b0, 1'b1);
        idle(6);
        check("noise_error", {31'd0, cfg_error}, 32'd0);

        // Reset at payload bit 10 after a committed frame
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_bit(p_a[i]);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_func",   {26'd0, conf_func_bus}, 32'd0);
        check("midrst_ins",    {8'd0, conf_ins_bus}, 32'd0);
        check("midrst_loaded", {31'd0, cfg_loaded}, 32'd0);
        check("midrst_busy",   {31'd0, busy}, 32'd0);
        check("midrst_ready",  {31'd0, cfg_ready}, 32'd1);
        exp_q.push_back(ev(1'b0, 6'b111_011, {12'h040, 12'h805}));
        send_frame(p_a, 1'b0, 1'b0);
        idle(6);

        // Sync pattern embedded in payload must not re-sync
        exp_q.push_back(ev(1'b0, 6'b010_101, {12'h1E0, 12'h7D4}));
        send_frame(p_e, 1'b0, 1'b0);
        idle(10);
        check("embedded_busy", {31'd0, busy}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
